alu_cmd_sender: RTL and testbench

Host-side command sequencer for the UART ALU link. It takes one ALU command (operand A, operand B, opcode) through a valid/ready handshake and serializes it as three bytes, A then B then opcode, into a `tx_uart` instance. It then waits for the single result byte from an `rx_uart` instance and presents that result with a one-cycle valid strobe. It drives the far end of the link, which rebuilds A, B and opcode for the ALU and returns the result byte. Benches and loopback tops use it in place of hand-driven `i_tx_start`/`i_data`.

---
 rtl/alu_link_pkg.sv | 24 ++
 rtl/alu_cmd_sender.sv | 113 +++++++++++
 tb/tb_alu_cmd_sender.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_link_pkg.sv
// Shared definitions for the UART ALU link.
// Byte order and state codes used by both link ends.
package alu_link_pkg;

  localparam int CMD_BYTES = 3;
  localparam int IDX_W     = 2;

  localparam logic [IDX_W-1:0] IDX_A  = 2'd0;
  localparam logic [IDX_W-1:0] IDX_B  = 2'd1;
  localparam logic [IDX_W-1:0] IDX_OP = 2'd2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_TX = 2'd2;
  localparam logic [1:0] S_WAIT_RX = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    SEND    = S_SEND,
    WAIT_TX = S_WAIT_TX,
    WAIT_RX = S_WAIT_RX
  } state_t;

endpackage

// File: rtl/alu_cmd_sender.sv
// Serializes one ALU command as A, B, opcode bytes
// and collects the single result byte.
module alu_cmd_sender
  import alu_link_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done_tick,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam logic [NB_TIMEOUT-1:0] LIMIT =
    NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [NB_DATA-1:0]      cmd [CMD_BYTES];
  logic [NB_TIMEOUT-1:0]   cnt;
  logic [NB_DATA-1:0]      op_ext;

  always_comb begin
    op_ext = '0;
    op_ext[NB_OP-1:0] = i_operation;
  end

  assign idx_nxt = idx + IDX_W'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      for (int i = 0; i < CMD_BYTES; i++)
        cmd[i] <= '0;
      o_cmd_ready    <= 1'b1;
      o_busy         <= 1'b0;
      o_tx_start     <= 1'b0;
      o_tx_data      <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_tx_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_timeout      <= 1'b0;
      case (state)
        IDLE: begin
          // start pulse is loaded on entry so it is visible in SEND
          if (i_cmd_valid) begin
            cmd[IDX_A]  <= i_data_a;
            cmd[IDX_B]  <= i_data_b;
            cmd[IDX_OP] <= op_ext;
            idx         <= IDX_A;
            o_tx_data   <= i_data_a;
            o_tx_start  <= 1'b1;
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (i_tx_done_tick) begin
            if (idx == IDX_OP) begin
              cnt   <= '0;
              state <= WAIT_RX;
            end else begin
              idx        <= idx_nxt;
              o_tx_data  <= cmd[idx_nxt];
              o_tx_start <= 1'b1;
              state      <= SEND;
            end
          end
        end
        WAIT_RX: begin
          cnt <= cnt + NB_TIMEOUT'(1);
          if (i_rx_done_tick) begin
            o_result       <= i_rx_data;
            o_result_valid <= 1'b1;
            o_cmd_ready    <= 1'b1;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end else if (cnt == LIMIT) begin
            o_timeout   <= 1'b1;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Directed bench for alu_cmd_sender with a
// delayed-done tx_uart model.
module tb_alu_cmd_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] data_a = '0;
  logic [7:0] data_b = '0;
  logic [5:0] operation = '0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic [7:0] result;
  logic       result_valid;
  logic       timeout;
  logic       busy;

  logic mdl_done = 1'b0;
  logic stray_tx = 1'b0;
  assign tx_done = mdl_done | stray_tx;

  alu_cmd_sender #(
    .NB_DATA(8),
    .NB_OP(6),
    .NB_TIMEOUT(20),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_data_a(data_a),
    .i_data_b(data_b),
    .i_operation(operation),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .i_tx_done_tick(tx_done),
    .i_rx_done_tick(rx_tick),
    .i_rx_data(rx_data),
    .o_result(result),
    .o_result_valid(result_valid),
    .o_timeout(timeout),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ncmp = 0;
  int nerr = 0;

  int dly = 0;
  int ndone = 0;
  int done_cyc = 0;
  int nvalid = 0;
  int ntmo = 0;
  int unstable = 0;
  logic [7:0] sq[$];
  int scyc[$];

  // tx_uart model: done tick 10 cycles after each start
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (rst) begin
      dly = 0;
    end else if (tx_start) begin
      sq.push_back(tx_data);
      scyc.push_back(cyc);
      dly = 10;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        mdl_done = 1'b1;
        ndone++;
        done_cyc = cyc;
        if (tx_data !== sq[$]) unstable++;
      end
    end
    if (result_valid) nvalid++;
    if (timeout) ntmo++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs_cyc = 0;

  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [5:0] op);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    data_a = a;
    data_b = b;
    operation = op;
    hs_cyc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (ndone < target && n < 300) begin
      tick();
      n++;
    end
    chk("done_wait", {31'd0, ndone >= target}, 1);
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_data = d;
    rx_tick = 1'b1;
    tick();
    rx_tick = 1'b0;
  endtask

  initial begin
    int b0, nv0, nt0, nd0, n;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_start", {31'd0, tx_start}, 0);
    chk("rst_txdata", {24'd0, tx_data}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_valid", {31'd0, result_valid}, 0);
    chk("rst_tmo", {31'd0, timeout}, 0);

    b0 = sq.size(); nv0 = nvalid; nd0 = ndone;
    send(8'h05, 8'h03, 6'h20);
    chk("send_start", {31'd0, tx_start}, 1);
    chk("send_ready", {31'd0, cmd_ready}, 0);
    chk("send_busy", {31'd0, busy}, 1);
    wait_done(nd0 + 3);
    repeat (3) tick();
    pulse_rx(8'h08);
    chk("res_val", {24'd0, result}, 32'h08);
    chk("res_vld", {31'd0, result_valid}, 1);
    chk("res_ready", {31'd0, cmd_ready}, 1);
    chk("res_busy", {31'd0, busy}, 0);
    repeat (2) tick();
    chk("n_starts", sq.size() - b0, 3);
    chk("byte_a", {24'd0, sq[b0]}, 32'h05);
    chk("byte_b", {24'd0, sq[b0+1]}, 32'h03);
    chk("byte_op", {24'd0, sq[b0+2]}, 32'h20);
    chk("hs_lat", scyc[b0] - hs_cyc, 1);
    chk("gap", scyc[b0+1] - scyc[b0], 11);
    chk("n_valid", nvalid - nv0, 1);
    chk("no_tmo", ntmo, 0);

    nv0 = nvalid; nd0 = ndone;
    send(8'h11, 8'h22, 6'h3f);
    wait_done(nd0 + 3);
    n = 0;
    while (!timeout && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_seen", {31'd0, timeout}, 1);
    chk("tmo_lat", cyc - done_cyc, 17);
    chk("tmo_ready", {31'd0, cmd_ready}, 1);
    chk("tmo_keep", {24'd0, result}, 32'h08);
    tick();
    chk("tmo_pulse", {31'd0, timeout}, 0);
    chk("tmo_count", ntmo, 1);
    chk("tmo_novld", nvalid - nv0, 0);
    chk("tmo_byte_op", {24'd0, sq[sq.size()-1]}, 32'h3f);

    nd0 = ndone;
    send(8'h44, 8'h55, 6'h2a);
    wait_done(nd0 + 3);
    n = 0;
    while (cyc != done_cyc + 16 && n < 50) begin
      tick();
      n++;
    end
    pulse_rx(8'ha5);
    chk("last_vld", {31'd0, result_valid}, 1);
    chk("last_tmo", {31'd0, timeout}, 0);
    chk("last_res", {24'd0, result}, 32'ha5);
    repeat (20) tick();
    chk("last_ntmo", ntmo, 1);

    b0 = sq.size(); nv0 = nvalid;
    rx_data = 8'h77;
    rx_tick = 1'b1;
    stray_tx = 1'b1;
    tick();
    rx_tick = 1'b0;
    stray_tx = 1'b0;
    repeat (2) tick();
    chk("stray_res", {24'd0, result}, 32'ha5);
    chk("stray_vld", nvalid - nv0, 0);
    chk("stray_start", sq.size() - b0, 0);
    chk("stray_busy", {31'd0, busy}, 0);

    nd0 = ndone;
    cmd_valid = 1'b1;
    data_a = 8'h10;
    data_b = 8'h20;
    operation = 6'h01;
    tick();
    for (int k = 1; k < 300 && ndone < nd0 + 3; k++) begin
      data_a = 8'h10 + 8'(k);
      data_b = 8'h20 + 8'(k);
      operation = 6'(k);
      rx_data = 8'hee;
      rx_tick = (k == 5);
      tick();
    end
    rx_tick = 1'b0;
    cmd_valid = 1'b0;
    chk("hold_done", {31'd0, ndone >= nd0 + 3}, 1);
    chk("hold_novld", nvalid - nv0, 0);
    repeat (2) tick();
    pulse_rx(8'h55);
    chk("hold_res", {24'd0, result}, 32'h55);
    repeat (15) tick();
    chk("hold_starts", sq.size() - b0, 3);
    chk("hold_a", {24'd0, sq[b0]}, 32'h10);
    chk("hold_b", {24'd0, sq[b0+1]}, 32'h20);
    chk("hold_op", {24'd0, sq[b0+2]}, 32'h01);
    chk("hold_nvld", nvalid - nv0, 1);
    chk("stable", unstable, 0);

    b0 = sq.size();
    send(8'h9a, 8'hbc, 6'h07);
    n = 0;
    while (sq.size() < b0 + 2 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, cmd_ready}, 1);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_start", {31'd0, tx_start}, 0);
    chk("mrst_txdata", {24'd0, tx_data}, 0);
    chk("mrst_result", {24'd0, result}, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    b0 = sq.size(); nd0 = ndone;
    send(8'h01, 8'h02, 6'h03);
    wait_done(nd0 + 3);
    pulse_rx(8'h04);
    chk("post_starts", sq.size() - b0, 3);
    chk("post_a", {24'd0, sq[b0]}, 32'h01);
    chk("post_b", {24'd0, sq[b0+1]}, 32'h02);
    chk("post_op", {24'd0, sq[b0+2]}, 32'h03);
    chk("post_res", {24'd0, result}, 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
